mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the five-stage CPU. It sits between the execute stage and the write-back stage, and it owns the word-addressed data memory. It performs loads with a configurable multi-cycle latency, stalling upstream while a load is pending, and performs single-cycle stores. It registers the 105-bit MEMWB bundle consumed by write-back.

## Interface
- DEPTH, 256: data memory size in 32-bit words; must be a power of two.
- AW, 8: word-address width, log2(DEPTH).
- LOAD_LAT, 2: cycles a load occupies the stage; must be 1 or more.
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- ex_valid  input  1  EX/MEM holds a valid instruction.
- ex_pc  input  32  PC of that instruction.
- ex_alu  input  32  ALU result; this is the byte address for loads and stores.
- ex_store_data  input  32  data to write on a store.
- ex_rd  input  5  destination register.
- ex_mem_read  input  1  the instruction is a load.
- ex_mem_write  input  1  the instruction is a store.
- ex_mem_to_reg  input  1  write-back selects memory data.
- ex_reg_write  input  1  the instruction writes the register file.
- ex_halt  input  1  halt instruction.
- stall  output  1  upstream must hold all ex_* inputs stable this cycle.
- MEMWB  output  105  registered bundle: [4:0] rd; [36:5] mem data; [68:37] ALU result; [69] mem_to_reg; [70] reg_write; [71] valid; [72] halt; [104:73] pc.
- halted  output  1  sticky flag: a halt has been emitted.
- misalign  output  1  sticky flag: a load or store had ex_alu[1:0] not equal to 0.

## Operation
- Word index into memory is ex_alu[AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH*4. Memory is not cleared by RST.
- Accept condition: an instruction is accepted on an edge where ex_valid=1, stall=0 and halted=0.
- Non-memory instruction:
  - MEMWB gets rd, alu, mem_to_reg, reg_write, valid=1, halt and pc.
  - The mem-data field is 0.
- Store:
  - mem[idx] is written with ex_store_data on the accept edge.
  - MEMWB has valid=1 and reg_write forced to 0.
- Load FSM, states IDLE and WAIT, with a counter cnt.
  - IDLE with a valid load and LOAD_LAT>1: stall=1. The next edge moves to WAIT with cnt=1 and loads a bubble into MEMWB.
  - WAIT: stall=(cnt != LOAD_LAT-1). The edge on which stall=0 captures mem[idx] into the mem-data field with the full load fields, then returns to IDLE. Otherwise cnt increments and MEMWB takes a bubble.
  - LOAD_LAT=1: the load completes like a non-memory instruction, with no stall.
- Bubble: all 105 bits of MEMWB are 0.
- A load or store with ex_alu[1:0] != 0:
  - The memory access is suppressed: no write, mem data is 0, no stall.
  - reg_write is forced to 0 and valid=1.
  - misalign is set.
- Halt:
  - The accepted halt instruction is emitted with bit[72]=1, and halted is set on the same edge.
  - Afterwards every edge loads a bubble; inputs are ignored until RST.
- A cycle with ex_valid=0 and stall=0 loads a bubble.
- Reset (asynchronous, any time, including mid-load):
  - MEMWB=0, halted=0, misalign=0, state=IDLE, cnt=0.
  - stall is forced to 0 while RST=1.
  - A pending load is dropped.

## Timing
- Non-memory instructions, stores and misaligned accesses: MEMWB is valid 1 edge after acceptance. Throughput is 1 per cycle.
- Aligned load: stall is high for LOAD_LAT-1 consecutive cycles. MEMWB is valid on the LOAD_LAT-th edge after the load first appears.
- Store followed by a load of the same word on the next cycle: the load returns the new data (write-before-read across edges).
- stall is combinational from state, cnt, ex_valid, ex_mem_read, the alignment check, halted and RST. It is never registered.
- All outputs other than stall change only on the CLK rising edge or on RST assertion.

## Test plan
- Reset, then an ALU op: rd=3, alu=0x10, reg_write=1 -> next edge MEMWB[4:0]=3, [68:37]=0x10, [70]=1, [71]=1; stall stays 0.
- Store 0xDEADBEEF to 0x40, then load 0x40 with rd=5, LOAD_LAT=2 -> stall high for exactly 1 cycle, one bubble emitted, then MEMWB[36:5]=0xDEADBEEF, [69]=1, [4:0]=5.
- Load at 0x400 with DEPTH=256 -> returns mem[0] (wrap); store at 0x3 -> memory unchanged, misalign=1, [70]=0, no stall.
- Halt instruction, then ALU ops -> MEMWB[72]=1 for one edge, halted=1, all subsequent MEMWB=0 until RST.
- RST asserted during a LOAD_LAT=3 load after 1 cycle -> MEMWB=0 and stall=0 immediately; after release, a fresh ALU op completes in 1 edge.
- Back-to-back ALU, load, ALU with LOAD_LAT=2 -> valid outputs on edges 1, 3 and 4, with a bubble on edge 2.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: owns the word-addressed data memory, runs
// multi-cycle loads behind a stall, does single-cycle stores, and registers
// the 105-bit MEMWB bundle consumed by write-back.
module mem_stage #(
    parameter int DEPTH    = 256,
    parameter int AW       = 8,
    parameter int LOAD_LAT = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ex_valid,
    input  logic [31:0]  ex_pc,
    input  logic [31:0]  ex_alu,
    input  logic [31:0]  ex_store_data,
    input  logic [4:0]   ex_rd,
    input  logic         ex_mem_read,
    input  logic         ex_mem_write,
    input  logic         ex_mem_to_reg,
    input  logic         ex_reg_write,
    input  logic         ex_halt,
    output logic         stall,
    output logic [104:0] MEMWB,
    output logic         halted,
    output logic         misalign
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam int            CW       = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_LAT - 1);
    localparam bit            MULTI    = (LOAD_LAT > 1);

    logic [31:0]   mem [DEPTH];

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [104:0]  memwb_q, memwb_d;
    logic          halted_q, halted_d;
    logic          misalign_q, misalign_d;

    logic [AW-1:0] idx;
    logic          aligned;
    logic          mem_op;
    logic          load_req;
    logic          accept;
    logic          mem_we;

    assign idx      = ex_alu[AW+1:2];
    assign aligned  = (ex_alu[1:0] == 2'b00);
    assign mem_op   = ex_mem_read | ex_mem_write;
    assign load_req = ex_valid & ex_mem_read & aligned & ~halted_q;
    assign accept   = ex_valid & ~stall & ~halted_q;
    assign mem_we   = accept & ex_mem_write & aligned & ~RST;

    // Stall while an aligned multi-cycle load has not reached its last cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stall = 1'b0;
        if (!RST && MULTI && load_req) begin
            stall = (state_q == S_IDLE) || (cnt_q != CNT_LAST);
        end
    end

    // Next-state for the load FSM, the MEMWB bundle and the sticky flags.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memwb_d    = '0;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        if (halted_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (stall) begin
            // Waiting on a load: MEMWB takes a bubble each cycle.
            if (state_q == S_IDLE) begin
                state_d = S_WAIT;
                cnt_d   = CW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (accept) begin
                memwb_d[4:0]    = ex_rd;
                memwb_d[36:5]   = (ex_mem_read && aligned) ? mem[idx] : 32'h0;
                memwb_d[68:37]  = ex_alu;
                memwb_d[69]     = ex_mem_to_reg;
                // Stores and misaligned accesses never write the register file.
                memwb_d[70]     = ex_reg_write & ~ex_mem_write & ~(mem_op & ~aligned);
                memwb_d[71]     = 1'b1;
                memwb_d[72]     = ex_halt;
                memwb_d[104:73] = ex_pc;
                halted_d        = halted_q | ex_halt;
                misalign_d      = misalign_q | (mem_op & ~aligned);
            end
        end
    end

    // Pipeline state registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            memwb_q    <= '0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memwb_q    <= memwb_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    // Data memory write port; a store becomes visible to the next cycle's read.
    always_ff @(posedge CLK) begin
        // NOTE: the memory array has no reset so it maps onto RAM; contents survive RST.
        if (mem_we) begin
            mem[idx] <= ex_store_data;
        end
    end

    assign MEMWB    = memwb_q;
    assign halted   = halted_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table for single-cycle behaviour
// plus hand-written sequences for loads, halt and reset mid-load.
module tb_mem_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        rw;
        logic        halt;
    } ex_t;

    typedef struct {
        string        name;
        ex_t          in;
        logic         exp_stall;
        logic [104:0] exp_wb;
        logic         exp_halted;
        logic         exp_misalign;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_halt;
    logic [31:0]  ex_pc, ex_alu, ex_store_data;
    logic [4:0]   ex_rd;
    logic         stall2, halted2, misalign2;
    logic [104:0] memwb2;
    logic         stall3, halted3, misalign3;
    logic [104:0] memwb3;

    int checks = 0;
    int errors = 0;

    vec_t vecs[7];

    always #5 CLK = ~CLK;

    mem_stage #(.DEPTH(256), .AW(8), .LOAD_LAT(2)) dut2 (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu(ex_alu),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_halt(ex_halt), .stall(stall2),
        .MEMWB(memwb2), .halted(halted2), .misalign(misalign2)
    );

    mem_stage #(.DEPTH(256), .AW(8), .LOAD_LAT(3)) dut3 (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu(ex_alu),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_reg_write(ex_reg_write), .ex_halt(ex_halt), .stall(stall3),
        .MEMWB(memwb3), .halted(halted3), .misalign(misalign3)
    );

    function automatic logic [104:0] wb(input logic [4:0] rd, input logic [31:0] md,
                                        input logic [31:0] alu, input logic m2r,
                                        input logic rw, input logic v, input logic h,
                                        input logic [31:0] pc);
        return {pc, h, v, rw, m2r, alu, md, rd};
    endfunction

    function automatic ex_t mk_ex(input logic valid, input logic [31:0] pc,
                                  input logic [31:0] alu, input logic [31:0] sd,
                                  input logic [4:0] rd, input logic mr, input logic mw,
                                  input logic m2r, input logic rw, input logic halt);
        ex_t e;
        e.valid = valid; e.pc = pc; e.alu = alu; e.sd = sd; e.rd = rd;
        e.mr = mr; e.mw = mw; e.m2r = m2r; e.rw = rw; e.halt = halt;
        return e;
    endfunction

    task automatic drive(input ex_t e);
        ex_valid      = e.valid;
        ex_pc         = e.pc;
        ex_alu        = e.alu;
        ex_store_data = e.sd;
        ex_rd         = e.rd;
        ex_mem_read   = e.mr;
        ex_mem_write  = e.mw;
        ex_mem_to_reg = e.m2r;
        ex_reg_write  = e.rw;
        ex_halt       = e.halt;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [104:0] act, input logic [104:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{"alu_rd3", mk_ex(1, 32'h100, 32'h10, 32'h0, 5'd3, 0, 0, 0, 1, 0),
                    1'b0, wb(5'd3, 32'h0, 32'h10, 0, 1, 1, 0, 32'h100), 1'b0, 1'b0};
        vecs[1] = '{"store_40", mk_ex(1, 32'h104, 32'h40, 32'hDEADBEEF, 5'd0, 0, 1, 0, 0, 0),
                    1'b0, wb(5'd0, 32'h0, 32'h40, 0, 0, 1, 0, 32'h104), 1'b0, 1'b0};
        vecs[2] = '{"store_0_rw_forced", mk_ex(1, 32'h108, 32'h0, 32'h12345678, 5'd2, 0, 1, 0, 1, 0),
                    1'b0, wb(5'd2, 32'h0, 32'h0, 0, 0, 1, 0, 32'h108), 1'b0, 1'b0};
        vecs[3] = '{"store_misaligned", mk_ex(1, 32'h10C, 32'h3, 32'hFFFFFFFF, 5'd1, 0, 1, 0, 1, 0),
                    1'b0, wb(5'd1, 32'h0, 32'h3, 0, 0, 1, 0, 32'h10C), 1'b0, 1'b1};
        vecs[4] = '{"bubble", mk_ex(0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0),
                    1'b0, 105'h0, 1'b0, 1'b1};
        vecs[5] = '{"load_misaligned", mk_ex(1, 32'h110, 32'h42, 32'h0, 5'd7, 1, 0, 1, 1, 0),
                    1'b0, wb(5'd7, 32'h0, 32'h42, 1, 0, 1, 0, 32'h110), 1'b0, 1'b1};
        vecs[6] = '{"alu_rd31", mk_ex(1, 32'h114, 32'hFFFFFFFC, 32'h0, 5'd31, 0, 0, 0, 1, 0),
                    1'b0, wb(5'd31, 32'h0, 32'hFFFFFFFC, 0, 1, 1, 0, 32'h114), 1'b0, 1'b1};

        // Reset state.
        drive(mk_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        step();
        check("rst_stall", {104'h0, stall2}, 105'h0);
        check("rst_memwb", memwb2, 105'h0);
        check("rst_flags", {103'h0, halted2, misalign2}, 105'h0);
        RST = 1'b0;

        // Single-cycle vectors.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].in);
            #1;
            check({vecs[i].name, "_stall"}, {104'h0, stall2}, {104'h0, vecs[i].exp_stall});
            step();
            check({vecs[i].name, "_memwb"}, memwb2, vecs[i].exp_wb);
            check({vecs[i].name, "_halted"}, {104'h0, halted2}, {104'h0, vecs[i].exp_halted});
            check({vecs[i].name, "_misalign"}, {104'h0, misalign2}, {104'h0, vecs[i].exp_misalign});
        end

        // Load after store: one stall cycle, one bubble, then the stored data.
        drive(mk_ex(1, 32'h118, 32'h40, 32'h0, 5'd5, 1, 0, 1, 1, 0));
        #1;
        check("ld40_stall_first", {104'h0, stall2}, 105'h1);
        step();
        check("ld40_bubble", memwb2, 105'h0);
        check("ld40_stall_last", {104'h0, stall2}, 105'h0);
        step();
        check("ld40_data", memwb2, wb(5'd5, 32'hDEADBEEF, 32'h40, 1, 1, 1, 0, 32'h118));

        // Load at 0x400 wraps to word 0; the misaligned store left it untouched.
        drive(mk_ex(1, 32'h11C, 32'h400, 32'h0, 5'd6, 1, 0, 1, 1, 0));
        #1;
        check("ldwrap_stall", {104'h0, stall2}, 105'h1);
        step();
        check("ldwrap_bubble", memwb2, 105'h0);
        step();
        check("ldwrap_data", memwb2, wb(5'd6, 32'h12345678, 32'h400, 1, 1, 1, 0, 32'h11C));

        // Back-to-back ALU, load, ALU.
        drive(mk_ex(1, 32'h120, 32'h1, 32'h0, 5'd1, 0, 0, 0, 1, 0));
        step();
        check("b2b_edge1", memwb2, wb(5'd1, 32'h0, 32'h1, 0, 1, 1, 0, 32'h120));
        drive(mk_ex(1, 32'h124, 32'h40, 32'h0, 5'd2, 1, 0, 1, 1, 0));
        step();
        check("b2b_edge2_bubble", memwb2, 105'h0);
        step();
        check("b2b_edge3_load", memwb2, wb(5'd2, 32'hDEADBEEF, 32'h40, 1, 1, 1, 0, 32'h124));
        drive(mk_ex(1, 32'h128, 32'h4, 32'h0, 5'd4, 0, 0, 0, 1, 0));
        step();
        check("b2b_edge4", memwb2, wb(5'd4, 32'h0, 32'h4, 0, 1, 1, 0, 32'h128));

        // Halt, then everything is ignored.
        drive(mk_ex(1, 32'h200, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 1));
        step();
        check("halt_emit", memwb2, wb(5'd0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h200));
        check("halt_flag", {104'h0, halted2}, 105'h1);
        drive(mk_ex(1, 32'h204, 32'h8, 32'h0, 5'd3, 0, 0, 0, 1, 0));
        step();
        check("halt_ignore_alu", memwb2, 105'h0);
        drive(mk_ex(1, 32'h208, 32'h40, 32'h0, 5'd5, 1, 0, 1, 1, 0));
        #1;
        check("halt_no_stall", {104'h0, stall2}, 105'h0);
        step();
        check("halt_ignore_load", memwb2, 105'h0);
        check("halt_sticky", {104'h0, halted2}, 105'h1);

        // Reset clears the sticky flags.
        RST = 1'b1;
        #1;
        check("rst2_flags", {103'h0, halted2, misalign2}, 105'h0);
        check("rst2_memwb", memwb2, 105'h0);
        step();
        RST = 1'b0;

        // Reset in the middle of a LOAD_LAT=3 load.
        drive(mk_ex(1, 32'h300, 32'h40, 32'h0, 5'd5, 1, 0, 1, 1, 0));
        #1;
        check("lat3_stall_c0", {104'h0, stall3}, 105'h1);
        step();
        check("lat3_stall_c1", {104'h0, stall3}, 105'h1);
        check("lat3_bubble", memwb3, 105'h0);
        #2;
        RST = 1'b1;
        #1;
        check("lat3_rst_stall", {104'h0, stall3}, 105'h0);
        check("lat3_rst_memwb", memwb3, 105'h0);
        check("lat2_rst_memwb", memwb2, 105'h0);
        step();
        RST = 1'b0;
        drive(mk_ex(1, 32'h304, 32'h90, 32'h0, 5'd9, 0, 0, 0, 1, 0));
        #1;
        check("lat3_post_stall", {104'h0, stall3}, 105'h0);
        step();
        check("lat3_post_alu", memwb3, wb(5'd9, 32'h0, 32'h90, 0, 1, 1, 0, 32'h304));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
